// File: rtl/top_level_pkg.sv
// Shared constants and types for the serial boxcar-filter block.
// Optional build macro: TOP_LEVEL_FIR_BYPASS_EN (filter replaced by a
// two-cycle pass-through of the deserialized word).
package top_level_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int FIR_DEPTH_DEF  = 256;
  // Averaging shift for the default depth: divide the running sum by FIR_DEPTH.
  localparam int FIR_SHIFT_DEF  = $clog2(FIR_DEPTH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/top_level_fir_filter.sv
// Boxcar FIR: running sum of the last FIR_DEPTH words, divided by FIR_DEPTH
// with an arithmetic shift. Result appears two enabled cycles after the input
// strobe. With TOP_LEVEL_FIR_BYPASS_EN defined the input word is passed
// through with the same latency and no delay line or accumulator exists.
module fir_filter
  import top_level_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIR_DEPTH  = FIR_DEPTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] fir_din,
  input  logic                  fir_din_valid,
  output logic [DATA_WIDTH-1:0] fir_dout,
  output logic                  fir_dout_valid
);

  logic                         vld_p1_q, vld_p1_d;
  logic                         vld_p2_q, vld_p2_d;
  logic signed [DATA_WIDTH-1:0] dout_p2_q, dout_p2_d;

`ifdef TOP_LEVEL_FIR_BYPASS_EN

  logic signed [DATA_WIDTH-1:0] din_p1_q, din_p1_d;

  // Next-state for the two-stage pass-through; nothing moves while disabled.
  always_comb begin
    din_p1_d  = din_p1_q;
    vld_p1_d  = vld_p1_q;
    dout_p2_d = dout_p2_q;
    vld_p2_d  = vld_p2_q;
    if (i_en) begin
      // stage p0 -> p1: capture the word
      vld_p1_d = fir_din_valid;
      if (fir_din_valid) din_p1_d = fir_din;
      // stage p1 -> p2: present the word
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) dout_p2_d = din_p1_q;
    end
  end

  // Pipeline registers for the pass-through.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      din_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      dout_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      din_p1_q  <= din_p1_d;
      vld_p1_q  <= vld_p1_d;
      dout_p2_q <= dout_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

`else

  // The packaged constant serves the default depth; other depths derive their own.
  localparam int SHIFT = (FIR_DEPTH == FIR_DEPTH_DEF) ? FIR_SHIFT_DEF : $clog2(FIR_DEPTH);
  // One extra bit per doubling of depth keeps the sum of FIR_DEPTH samples exact.
  localparam int ACC_W = DATA_WIDTH + SHIFT;

  logic signed [DATA_WIDTH-1:0] line_q [FIR_DEPTH];
  logic signed [DATA_WIDTH-1:0] line_d [FIR_DEPTH];
  logic        [SHIFT-1:0]      ptr_q, ptr_d;
  logic signed [ACC_W-1:0]      sum_q, sum_d;
  logic signed [DATA_WIDTH-1:0] oldest;
  logic signed [ACC_W-1:0]      din_ext, old_ext;

  // Divide by FIR_DEPTH (arithmetic shift) and keep the sample width; the
  // mean of FIR_DEPTH samples always fits, so truncation never loses sign.
  function automatic logic signed [DATA_WIDTH-1:0] avg_trunc(input logic signed [ACC_W-1:0] s);
    avg_trunc = DATA_WIDTH'(s >>> SHIFT);
  endfunction

  // The slot about to be overwritten holds the sample from FIR_DEPTH words ago.
  assign oldest  = line_q[ptr_q];
  assign din_ext = {{SHIFT{fir_din[DATA_WIDTH-1]}}, fir_din};
  assign old_ext = {{SHIFT{oldest[DATA_WIDTH-1]}}, oldest};

  // Next-state for delay line, running sum and output; nothing moves while disabled.
  always_comb begin
    line_d    = line_q;
    ptr_d     = ptr_q;
    sum_d     = sum_q;
    vld_p1_d  = vld_p1_q;
    dout_p2_d = dout_p2_q;
    vld_p2_d  = vld_p2_q;
    if (i_en) begin
      // stage p0 -> p1: swap newest sample in, oldest out of the running sum
      vld_p1_d = fir_din_valid;
      if (fir_din_valid) begin
        line_d[ptr_q] = fir_din;
        ptr_d         = ptr_q + 1'b1;
        sum_d         = sum_q + din_ext - old_ext;
      end
      // stage p1 -> p2: scale the sum to the average
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) dout_p2_d = avg_trunc(sum_q);
    end
  end

  // Filter state registers; reset empties the delay line so the sum restarts at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIR_DEPTH; i++) line_q[i] <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      vld_p1_q  <= 1'b0;
      dout_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      line_q    <= line_d;
      ptr_q     <= ptr_d;
      sum_q     <= sum_d;
      vld_p1_q  <= vld_p1_d;
      dout_p2_q <= dout_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

`endif

  assign fir_dout       = dout_p2_q;
  assign fir_dout_valid = vld_p2_q;

endmodule

// File: rtl/top_level.sv
// Serial-in / serial-out boxcar filter. Bits arrive LSB first and are
// gathered into a word, the word goes through fir_filter, and the result is
// shifted out LSB first under downstream back-pressure. Input is refused from
// word completion until the last result bit leaves, so one word is in flight.
// Optional build macro: TOP_LEVEL_FIR_BYPASS_EN (handled inside fir_filter).
module top_level
  import top_level_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIR_DEPTH  = FIR_DEPTH_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din,
  input  logic i_din_valid,
  input  logic i_ready,
  output logic o_ready,
  output logic o_dout,
  output logic o_dout_valid
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] fir_din_q, fir_din_d;
  logic                  fir_din_valid_q, fir_din_valid_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] fir_dout;
  logic                  fir_dout_valid;

  ser_state_e            ser_state_q;
  logic [CNT_W-1:0]      ser_idx_q;
  logic [DATA_WIDTH-1:0] ser_word_q;

  logic                  accept;
  logic                  last_in;
  logic                  ser_emit;
  logic                  ser_last;

  assign o_ready  = i_en & ~i_rst & ~busy_q;
  assign accept   = i_en & i_din_valid & o_ready;
  assign last_in  = accept & (bit_cnt_q == LAST_BIT);

  assign ser_emit = (ser_state_q == SHIFT) & i_ready & i_en & ~i_rst;
  assign ser_last = ser_emit & (ser_idx_q == LAST_BIT);

  assign o_dout_valid = ser_emit;
  assign o_dout       = ser_emit & ser_word_q[ser_idx_q];

  // Deserializer next-state: place accepted bits, hand off a complete word, track busy.
  always_comb begin
    bit_cnt_d       = bit_cnt_q;
    word_d          = word_q;
    fir_din_d       = fir_din_q;
    fir_din_valid_d = fir_din_valid_q;
    busy_d          = busy_q;
    if (i_en) begin
      fir_din_valid_d = 1'b0;
      if (accept) begin
        word_d[bit_cnt_q] = i_din;
        if (last_in) begin
          fir_din_d       = word_d;
          fir_din_valid_d = 1'b1;
          bit_cnt_d       = '0;
          busy_d          = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      // Input reopens once the final result bit has been taken downstream.
      if (ser_last) busy_d = 1'b0;
    end
  end

  // Deserializer registers; reset drops any partial word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt_q       <= '0;
      word_q          <= '0;
      fir_din_q       <= '0;
      fir_din_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      bit_cnt_q       <= bit_cnt_d;
      word_q          <= word_d;
      fir_din_q       <= fir_din_d;
      fir_din_valid_q <= fir_din_valid_d;
      busy_q          <= busy_d;
    end
  end

  fir_filter #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIR_DEPTH  (FIR_DEPTH)
  ) u_fir (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_en           (i_en),
    .fir_din        (fir_din_q),
    .fir_din_valid  (fir_din_valid_q),
    .fir_dout       (fir_dout),
    .fir_dout_valid (fir_dout_valid)
  );

  // Serializer FSM: load a filter result, then step one bit per downstream-ready cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ser_state_q <= IDLE;
      ser_idx_q   <= '0;
      ser_word_q  <= '0;
    end else if (i_en) begin
      case (ser_state_q)
        IDLE: begin
          if (fir_dout_valid) begin
            ser_word_q  <= fir_dout;
            ser_idx_q   <= '0;
            ser_state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_ready) begin
            if (ser_idx_q == LAST_BIT) begin
              ser_idx_q   <= '0;
              ser_state_q <= IDLE;
            end else begin
              ser_idx_q <= ser_idx_q + 1'b1;
            end
          end
        end
        default: ser_state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: directed words plus randomized words, gaps, enable
// drops and back-pressure, checked against a moving-average model that keeps
// the last FIR_DEPTH words in a queue and averages them with plain arithmetic.
`timescale 1ns/1ps
module tb_top_level;

  localparam int W  = 24;
  localparam int D  = 256;
  localparam int SH = 8;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_en;
  logic i_din;
  logic i_din_valid;
  logic i_ready;
  logic o_ready;
  logic o_dout;
  logic o_dout_valid;

  always #5 i_clk = ~i_clk;

  top_level #(.DATA_WIDTH(W), .FIR_DEPTH(D)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .i_ready      (i_ready),
    .o_ready      (o_ready),
    .o_dout       (o_dout),
    .o_dout_valid (o_dout_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0] hist[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_log[$];
  logic [W-1:0] in_word, rx_word, last_rx;
  int           in_cnt = 0;
  int           rx_cnt = 0;

  function automatic logic [W-1:0] model_word(input logic [W-1:0] w);
    longint acc;
    longint avg;
    logic [W-1:0] r;
    hist.push_back(w);
    if (hist.size() > D) void'(hist.pop_front());
`ifdef TOP_LEVEL_FIR_BYPASS_EN
    r = w;
`else
    acc = 0;
    foreach (hist[i]) acc += longint'($signed(hist[i]));
    avg = acc >>> SH;
    r   = avg[W-1:0];
`endif
    return r;
  endfunction

  // Monitor: reassemble accepted input words and emitted output words.
  always @(negedge i_clk) begin
    if (i_rst) begin
      in_cnt = 0;
      rx_cnt = 0;
      hist.delete();
      exp_q.delete();
    end else begin
      if (!i_en) begin
        check_eq("en_low_o_ready", o_ready, 0);
        check_eq("en_low_o_dout_valid", o_dout_valid, 0);
      end
      if (i_en && i_din_valid && o_ready) begin
        in_word[in_cnt] = i_din;
        in_cnt++;
        if (in_cnt == W) begin
          exp_q.push_back(model_word(in_word));
          in_cnt = 0;
        end
      end
      if (o_dout_valid) begin
        rx_word[rx_cnt] = o_dout;
        rx_cnt++;
        if (rx_cnt == W) begin
          rx_cnt  = 0;
          last_rx = rx_word;
          rx_log.push_back(rx_word);
          check_eq("rx_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check_eq("rx_word", rx_word, exp_q.pop_front());
        end
      end
    end
  end

  // Background driver for i_ready / i_en (random modes and forced stalls).
  int ready_mode = 0;
  int en_mode    = 0;
  int stall_left = 0;
  initial begin
    i_ready = 1'b1;
    i_en    = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      if (stall_left > 0) begin
        i_ready    = 1'b0;
        stall_left = stall_left - 1;
      end else if (ready_mode == 1) begin
        i_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_ready = 1'b1;
      end
      i_en = (en_mode == 1) ? ($urandom_range(0, 7) != 0) : 1'b1;
    end
  end

  task automatic send_bits(input logic [W-1:0] w, input int nbits, input int gap_max);
    int  gap;
    int  t;
    bit  acc;
    for (int b = 0; b < nbits; b++) begin
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gap) begin
        i_din_valid = 1'b0;
        i_din       = 1'($urandom_range(0, 1));
        @(posedge i_clk);
        #1;
      end
      i_din       = w[b];
      i_din_valid = 1'b1;
      t   = 0;
      acc = 1'b0;
      while (!acc && t < 3000) begin
        @(negedge i_clk);
        acc = o_ready;
        @(posedge i_clk);
        #1;
        t++;
      end
      check_eq("bit_accepted", acc, 1);
      if (!acc) begin
        i_din_valid = 1'b0;
        return;
      end
    end
    i_din_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge i_clk);
      t++;
    end
    #1;
    check_eq("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    @(negedge i_clk);
    while (!o_dout_valid && t < 500) begin
      @(negedge i_clk);
      t++;
    end
    check_eq("out_started", o_dout_valid, 1);
  endtask

  int run;

  initial begin
    i_rst       = 1'b1;
    i_din       = 1'b0;
    i_din_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_o_ready", o_ready, 0);
    check_eq("rst_o_dout_valid", o_dout_valid, 0);
    check_eq("rst_o_dout", o_dout, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check_eq("post_rst_o_ready", o_ready, 1);

    // 0xA5A5A5 lands in fir_din one cycle after its last bit
    @(posedge i_clk);
    #1;
    send_bits(24'hA5A5A5, W, 0);
    @(negedge i_clk);
    check_eq("fir_din_a5", dut.fir_din_q, 24'hA5A5A5);
    check_eq("fir_din_valid_a5", dut.fir_din_valid_q, 1);
    check_eq("o_ready_busy", o_ready, 0);
    drain();
`ifdef TOP_LEVEL_FIR_BYPASS_EN
    check_eq("a5_out", last_rx, 24'hA5A5A5);
`else
    check_eq("a5_out", last_rx, 24'hFFA5A5);
`endif

    // -256 alone averages to -1, sent as 24 back-to-back bits
    do_reset();
    send_bits(24'hFFFF00, W, 0);
    wait_out_valid();
    run = 0;
    while (o_dout_valid && run < 40) begin
      run++;
      @(negedge i_clk);
    end
    #1;
    check_eq("run_len", run, W);
`ifdef TOP_LEVEL_FIR_BYPASS_EN
    check_eq("neg256_out", last_rx, 24'hFFFF00);
`else
    check_eq("neg256_out", last_rx, 24'hFFFFFF);
`endif

    // Constant 0x100 stream: ramp 1..256 then saturates at 0x100
    do_reset();
    rx_log.delete();
    for (int k = 0; k < 300; k++) send_bits(24'h000100, W, 0);
    drain();
    check_eq("ramp_count", rx_log.size(), 300);
`ifdef TOP_LEVEL_FIR_BYPASS_EN
    check_eq("ramp_k1", rx_log[0], 24'h000100);
    check_eq("ramp_k257", rx_log[256], 24'h000100);
`else
    check_eq("ramp_k1", rx_log[0], 24'd1);
    check_eq("ramp_k2", rx_log[1], 24'd2);
    check_eq("ramp_k256", rx_log[255], 24'd256);
    check_eq("ramp_k257", rx_log[256], 24'h000100);
    check_eq("ramp_k300", rx_log[299], 24'h000100);
`endif

    // Five-cycle downstream stall mid-word
    do_reset();
    send_bits(24'h5A3C96, W, 1);
    wait_out_valid();
    repeat (8) @(negedge i_clk);
    stall_left = 5;
    repeat (5) begin
      @(negedge i_clk);
      check_eq("stall_valid_low", o_dout_valid, 0);
    end
    drain();
`ifdef TOP_LEVEL_FIR_BYPASS_EN
    check_eq("stall_out", last_rx, 24'h5A3C96);
`else
    check_eq("stall_out", last_rx, 24'h005A3C);
`endif

    // Reset after 10 input bits discards the partial word
    do_reset();
    send_bits(24'hFFFFFF, 10, 0);
    do_reset();
    send_bits(24'h123456, W, 0);
    @(negedge i_clk);
    check_eq("fir_din_123456", dut.fir_din_q, 24'h123456);
    drain();
`ifdef TOP_LEVEL_FIR_BYPASS_EN
    check_eq("reset_mid_out", last_rx, 24'h123456);
`else
    check_eq("reset_mid_out", last_rx, 24'h001234);
`endif

    // Largest positive sample
    do_reset();
    send_bits(24'h7FFFFF, W, 0);
    drain();
`ifdef TOP_LEVEL_FIR_BYPASS_EN
    check_eq("max_pos_out", last_rx, 24'h7FFFFF);
`else
    check_eq("max_pos_out", last_rx, 24'h007FFF);
`endif

    // Randomized words, gaps, enable drops and back-pressure
    do_reset();
    ready_mode = 1;
    en_mode    = 1;
    send_bits(24'h800000, W, 2);
    send_bits(24'h7FFFFF, W, 2);
    repeat (40) send_bits(24'($urandom()), W, 2);
    drain();
    ready_mode = 0;
    en_mode    = 0;
    repeat (3) @(posedge i_clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, sample width in bits (two's-complement).
REQ-002 SHALL have parameter FIR_DEPTH, default 256, number of filter taps; power of two, at least 2.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port i_en, input, 1, global enable; when low all state holds, o_ready=0, o_dout_valid=0.
REQ-006 SHALL have port i_din, input, 1, serial input bit, LSB first.
REQ-007 SHALL have port i_din_valid, input, 1, i_din carries a bit this cycle.
REQ-008 SHALL have port i_ready, input, 1, downstream accepts an output bit this cycle.
REQ-009 SHALL have port o_ready, output, 1, block accepts an input bit this cycle.
REQ-010 SHALL have port o_dout, output, 1, serial output bit, LSB first.
REQ-011 SHALL have port o_dout_valid, output, 1, o_dout carries a bit this cycle.

Function
REQ-012 SHALL accept a bit on each edge where i_en, i_din_valid and o_ready are all high; accepted bit k (0..DATA_WIDTH-1) lands in word position k.
REQ-013 SHALL, on the edge accepting bit DATA_WIDTH-1, load internal register fir_din with the complete word, pulse fir_din_valid for one cycle and clear the bit counter.
REQ-014 SHALL compute a boxcar FIR: running sum of the last FIR_DEPTH samples (delay line initially zero), arithmetic right shift by log2(FIR_DEPTH), truncated to DATA_WIDTH.
REQ-015 SHALL update the sum as sum + new - oldest; oldest is the sample written FIR_DEPTH words earlier; delay-line pointer wraps modulo FIR_DEPTH.
REQ-016 SHALL size the accumulator DATA_WIDTH+log2(FIR_DEPTH) bits signed, so no overflow occurs.
REQ-017 SHALL register the result in internal register fir_dout with fir_dout_valid pulse exactly 2 cycles after fir_din_valid; fir_dout holds until the next result.
REQ-018 SHALL load the serializer on fir_dout_valid and, from the next cycle, drive o_dout_valid=1 with o_dout = fir_dout bit k for each k, LSB first, advancing only on edges where i_ready and i_en are high.
REQ-019 SHALL hold o_dout, o_dout_valid low and the bit index while i_ready is low.
REQ-020 SHALL drive o_ready low from the cycle after a word completes until the edge on which the serializer emits its last bit; otherwise o_ready = i_en.
REQ-021 SHALL ignore i_din while o_ready is low; i_din_valid without o_ready is not an error.

Reset
REQ-022 SHALL, on i_rst, clear bit counter, fir_din, fir_dout, sum, delay line, pointer and serializer; o_ready=0, o_dout=0, o_dout_valid=0 during reset.
REQ-023 SHALL discard any partial input word or partly sent output word on reset mid-operation; o_ready returns to i_en the cycle after reset deasserts.

Configuration
REQ-024 SHALL, with macro TOP_LEVEL_FIR_BYPASS_EN defined, set fir_dout = fir_din (same 2-cycle latency, no delay line or accumulator); without it, behave per REQ-014..REQ-016.

Structure
REQ-025 SHALL place default widths, the log2(FIR_DEPTH) shift constant and the serializer state enum (IDLE, SHIFT) in package top_level_pkg.
REQ-026 SHALL implement the filter as sub-module fir_filter (fir_din/fir_din_valid in, fir_dout/fir_dout_valid out); the deserializer and serializer stay in top_level.

Verification
REQ-027 SHALL check: send word 0xA5A5A5 LSB first -> fir_din == 0xA5A5A5 one cycle after the last bit is accepted.
REQ-028 SHALL check: after reset, send 0xFFFF00 (-256) -> serial output word 0xFFFFFF (-1) over 24 consecutive o_dout_valid cycles.
REQ-029 SHALL check: send 0x000100 k times (k=1..256) -> k-th output == k; 257th and later outputs == 0x000100 (wrap-around).
REQ-030 SHALL check: i_ready low for 5 cycles mid-output -> o_dout_valid low those cycles; the resumed bit stream equals the uninterrupted one.
REQ-031 SHALL check: i_rst asserted after 10 input bits -> next full word 0x123456 is received intact; first output is 0x123456>>>8 = 0x001234.
REQ-032 SHALL check: with TOP_LEVEL_FIR_BYPASS_EN, send 0x7FFFFF -> output 0x7FFFFF.
